// File: rtl/axil_reg_bridge_pkg.sv
// Shared types for the AXI4-Lite to register-port bridge: response codes,
// read/write FSM state encodings and the byte-to-word address shift.
package sys_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ISSUE,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_RESP
  } rd_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int WORD_SHIFT = $clog2(DEFAULT_DATA_WIDTH / 8);

  function automatic int word_shift(input int dataWidth);
    return $clog2(dataWidth / 8);
  endfunction

endpackage

// File: rtl/axil_reg_bridge_if.sv
// AXI4-Lite slave channel bundle; the bridge takes the slave modport and the
// processor side (or a testbench) takes the master modport.
interface axil_reg_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);

  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr;
  logic                        s_awvalid;
  logic                        s_awready;

  logic [AXI_DATA_WIDTH-1:0]   s_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb;
  logic                        s_wvalid;
  logic                        s_wready;

  logic [1:0]                  s_bresp;
  logic                        s_bvalid;
  logic                        s_bready;

  logic [AXI_ADDR_WIDTH-1:0]   s_araddr;
  logic                        s_arvalid;
  logic                        s_arready;

  logic [AXI_DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]                  s_rresp;
  logic                        s_rvalid;
  logic                        s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, output s_awready,
    input  s_wdata, s_wstrb, s_wvalid, output s_wready,
    output s_bresp, s_bvalid, input s_bready,
    input  s_araddr, s_arvalid, output s_arready,
    output s_rdata, s_rresp, s_rvalid, input s_rready
  );

  modport master (
    output s_awaddr, s_awvalid, input s_awready,
    output s_wdata, s_wstrb, s_wvalid, input s_wready,
    input  s_bresp, s_bvalid, output s_bready,
    output s_araddr, s_arvalid, input s_arready,
    input  s_rdata, s_rresp, s_rvalid, output s_rready
  );

endinterface

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that turns single-beat reads and writes into one-cycle
// register strobes for the DMA controller, with SLVERR for bad index/strobe.
module axil_reg_bridge
  import sys_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  axil_reg_bridge_if.slave          s_axil,
  output logic                      reg_wr_en,
  output logic [AXI_ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0] reg_wr_data,
  output logic                      reg_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] reg_rd_data
);

  localparam int SHIFT = word_shift(AXI_DATA_WIDTH);
  localparam int STRBW = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] LAST_IDX = AXI_ADDR_WIDTH'(NUM_REGS);

  wr_state_t                 r_wrState;
  logic                      r_awHeld;
  logic                      r_wHeld;
  logic [AXI_ADDR_WIDTH-1:0] r_awIdx;
  logic [AXI_DATA_WIDTH-1:0] r_wData;
  logic [STRBW-1:0]          r_wStrb;
  logic                      r_wrOk;
  logic                      r_wrEn;
  logic [AXI_ADDR_WIDTH-1:0] r_wrAddr;
  logic [AXI_DATA_WIDTH-1:0] r_wrData;
  logic                      r_bValid;
  axi_resp_t                 r_bResp;

  rd_state_t                 r_rdState;
  logic                      r_rdOk;
  logic                      r_rdEn;
  logic [AXI_ADDR_WIDTH-1:0] r_rdAddr;
  logic                      r_rValid;
  axi_resp_t                 r_rResp;
  logic [AXI_DATA_WIDTH-1:0] r_rData;

  logic                      w_awHs;
  logic                      w_wHs;
  logic                      w_arHs;
  logic [AXI_ADDR_WIDTH-1:0] w_wrIdx;
  logic [AXI_DATA_WIDTH-1:0] w_wrDataSel;
  logic [STRBW-1:0]          w_wrStrbSel;
  logic                      w_wrOk;
  logic                      w_wrGo;
  logic [AXI_ADDR_WIDTH-1:0] w_rdIdx;
  logic                      w_rdOk;

  assign s_axil.s_awready = !r_awHeld;
  assign s_axil.s_wready  = !r_wHeld;
  assign s_axil.s_arready = (r_rdState == RD_IDLE);

  assign w_awHs = s_axil.s_awvalid && !r_awHeld;
  assign w_wHs  = s_axil.s_wvalid && !r_wHeld;
  assign w_arHs = s_axil.s_arvalid && (r_rdState == RD_IDLE);

  // Look through to the bus when a channel handshakes this cycle, so the
  // strobe lands one cycle after the last of AW/W instead of two.
  assign w_wrIdx     = r_awHeld ? r_awIdx : (s_axil.s_awaddr >> SHIFT);
  assign w_wrDataSel = r_wHeld ? r_wData : s_axil.s_wdata;
  assign w_wrStrbSel = r_wHeld ? r_wStrb : s_axil.s_wstrb;
  assign w_wrOk      = (w_wrIdx < LAST_IDX) && (&w_wrStrbSel);
  assign w_wrGo      = (r_wrState == WR_IDLE) && (r_awHeld || w_awHs) && (r_wHeld || w_wHs);

  assign w_rdIdx = s_axil.s_araddr >> SHIFT;
  assign w_rdOk  = (w_rdIdx < LAST_IDX);

  assign s_axil.s_bvalid = r_bValid;
  assign s_axil.s_bresp  = r_bResp;
  assign s_axil.s_rvalid = r_rValid;
  assign s_axil.s_rresp  = r_rResp;
  assign s_axil.s_rdata  = r_rData;

  assign reg_wr_en   = r_wrEn;
  assign reg_wr_addr = r_wrAddr;
  assign reg_wr_data = r_wrData;
  assign reg_rd_en   = r_rdEn;
  assign reg_rd_addr = r_rdAddr;

  // Write path: AW and W are captured independently into holding flags and
  // both flags stay set until the B handshake, which blocks further writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrState <= WR_IDLE;
      r_awHeld  <= 1'b0;
      r_wHeld   <= 1'b0;
      r_awIdx   <= '0;
      r_wData   <= '0;
      r_wStrb   <= '0;
      r_wrOk    <= 1'b0;
      r_wrEn    <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
      r_bValid  <= 1'b0;
      r_bResp   <= OKAY;
    end else begin
      r_wrEn <= 1'b0;
      if (w_awHs) begin
        r_awHeld <= 1'b1;
        r_awIdx  <= s_axil.s_awaddr >> SHIFT;
      end
      if (w_wHs) begin
        r_wHeld <= 1'b1;
        r_wData <= s_axil.s_wdata;
        r_wStrb <= s_axil.s_wstrb;
      end
      case (r_wrState)
        WR_IDLE: begin
          if (w_wrGo) begin
            r_wrState <= WR_ISSUE;
            r_wrOk    <= w_wrOk;
            r_wrEn    <= w_wrOk;
            if (w_wrOk) begin
              r_wrAddr <= w_wrIdx;
              r_wrData <= w_wrDataSel;
            end
          end
        end
        WR_ISSUE: begin
          r_bValid  <= 1'b1;
          r_bResp   <= r_wrOk ? OKAY : SLVERR;
          r_wrState <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axil.s_bready) begin
            r_bValid  <= 1'b0;
            r_awHeld  <= 1'b0;
            r_wHeld   <= 1'b0;
            r_wrState <= WR_IDLE;
          end
        end
        default: r_wrState <= WR_IDLE;
      endcase
    end
  end

  // Read path: reg_rd_data is combinational on reg_rd_addr, so it is sampled
  // during the issue cycle and held in s_rdata until the R handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdState <= RD_IDLE;
      r_rdOk    <= 1'b0;
      r_rdEn    <= 1'b0;
      r_rdAddr  <= '0;
      r_rValid  <= 1'b0;
      r_rResp   <= OKAY;
      r_rData   <= '0;
    end else begin
      r_rdEn <= 1'b0;
      case (r_rdState)
        RD_IDLE: begin
          if (w_arHs) begin
            r_rdState <= RD_ISSUE;
            r_rdOk    <= w_rdOk;
            r_rdEn    <= w_rdOk;
            if (w_rdOk) begin
              r_rdAddr <= w_rdIdx;
            end
          end
        end
        RD_ISSUE: begin
          r_rValid  <= 1'b1;
          r_rResp   <= r_rdOk ? OKAY : SLVERR;
          r_rData   <= r_rdOk ? reg_rd_data : '0;
          r_rdState <= RD_RESP;
        end
        RD_RESP: begin
          if (s_axil.s_rready) begin
            r_rValid  <= 1'b0;
            r_rdState <= RD_IDLE;
          end
        end
        default: r_rdState <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Scoreboard bench for axil_reg_bridge: stimulus pushes expected strobes and
// responses from a word-array model, a negedge monitor pops and compares.
module tb_axil_reg_bridge;
  import sys_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  axil_reg_bridge_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  logic          regWrEn;
  logic [AW-1:0] regWrAddr;
  logic [DW-1:0] regWrData;
  logic          regRdEn;
  logic [AW-1:0] regRdAddr;
  logic [DW-1:0] regRdData;

  axil_reg_bridge #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .NUM_REGS(NREG)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_axil(bus),
    .reg_wr_en(regWrEn),
    .reg_wr_addr(regWrAddr),
    .reg_wr_data(regWrData),
    .reg_rd_en(regRdEn),
    .reg_rd_addr(regRdAddr),
    .reg_rd_data(regRdData)
  );

  // Downstream register file standing in for the DMA controller
  logic [DW-1:0] regFile [NREG];
  always @(posedge clk) begin
    if (regWrEn && regWrAddr < NREG) regFile[regWrAddr[3:0]] <= regWrData;
  end
  assign regRdData = (regRdAddr < NREG) ? regFile[regRdAddr[3:0]] : 32'hBAD0_BAD0;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct { logic [AW-1:0] idx; logic [DW-1:0] data; } wrEvt_t;
  typedef struct { logic [DW-1:0] data; logic [1:0] resp; } rEvt_t;

  wrEvt_t        expWrQ [$];
  logic [AW-1:0] expRdQ [$];
  logic [1:0]    expBQ  [$];
  rEvt_t         expRQ  [$];
  logic [DW-1:0] model  [NREG];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a write lands only for whole-word strobes inside the map
  task automatic expectWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, output logic ok);
    int idx;
    idx = int'(addr / 4);
    ok  = (idx < NREG) && (strb == 4'hF);
    if (ok) begin
      expWrQ.push_back('{idx: AW'(idx), data: data});
      model[idx] = data;
      expBQ.push_back(2'b00);
    end else begin
      expBQ.push_back(2'b10);
    end
  endtask

  task automatic expectRead(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp, output logic ok);
    int idx;
    idx = int'(addr / 4);
    ok  = (idx < NREG);
    data = ok ? model[idx] : '0;
    resp = ok ? 2'b00 : 2'b10;
    if (ok) expRdQ.push_back(AW'(idx));
    expRQ.push_back('{data: data, resp: resp});
  endtask

  // Monitor: every strobe and every response handshake consumes one entry
  always @(negedge clk) begin
    wrEvt_t we;
    rEvt_t  re;
    logic [AW-1:0] ri;
    logic [1:0] br;
    if (regWrEn) begin
      if (expWrQ.size() == 0) checkOutput("unexpectedWrEn", 1, 0);
      else begin
        we = expWrQ.pop_front();
        checkOutput("wrAddr", regWrAddr, we.idx);
        checkOutput("wrData", regWrData, we.data);
      end
    end
    if (regRdEn) begin
      if (expRdQ.size() == 0) checkOutput("unexpectedRdEn", 1, 0);
      else begin
        ri = expRdQ.pop_front();
        checkOutput("rdAddr", regRdAddr, ri);
      end
    end
    if (bus.s_bvalid && bus.s_bready) begin
      if (expBQ.size() == 0) checkOutput("unexpectedB", 1, 0);
      else begin
        br = expBQ.pop_front();
        checkOutput("bresp", bus.s_bresp, br);
      end
    end
    if (bus.s_rvalid && bus.s_rready) begin
      if (expRQ.size() == 0) checkOutput("unexpectedR", 1, 0);
      else begin
        re = expRQ.pop_front();
        checkOutput("rdata", bus.s_rdata, re.data);
        checkOutput("rresp", bus.s_rresp, re.resp);
      end
    end
  end

  // Channel drivers start and end just after a rising edge
  task automatic driveAw(input logic [AW-1:0] addr, input int delay, input logic chkHold);
    int t;
    repeat (delay) begin @(posedge clk); #1; end
    if (chkHold) begin
      checkOutput("wreadyWhileHeld", bus.s_wready, 0);
      checkOutput("noWrEnBeforeAw", regWrEn, 0);
    end
    bus.s_awaddr  = addr;
    bus.s_awvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.s_awready && t < 50);
    if (!bus.s_awready) checkOutput("awTimeout", 0, 1);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
  endtask

  task automatic driveW(input logic [DW-1:0] data, input logic [3:0] strb, input int delay);
    int t;
    repeat (delay) begin @(posedge clk); #1; end
    bus.s_wdata  = data;
    bus.s_wstrb  = strb;
    bus.s_wvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.s_wready && t < 50);
    if (!bus.s_wready) checkOutput("wTimeout", 0, 1);
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0;
  endtask

  task automatic driveAr(input logic [AW-1:0] addr);
    int t;
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.s_arready && t < 50);
    if (!bus.s_arready) checkOutput("arTimeout", 0, 1);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                         input int awD, input int wD, input int stall, input logic ok);
    int lat, wrLat;
    fork
      driveAw(addr, awD, (wD == 0) && (awD >= 2));
      driveW(data, strb, wD);
    join
    lat = 0; wrLat = 0;
    do begin
      @(negedge clk); lat++;
      if (regWrEn && wrLat == 0) wrLat = lat;
    end while (!bus.s_bvalid && lat < 20);
    checkOutput("bLatency", lat, 2);
    checkOutput("wrEnLatency", wrLat, ok ? 1 : 0);
    repeat (stall) begin
      @(negedge clk);
      checkOutput("bvalidHeld", bus.s_bvalid, 1);
      checkOutput("brespHeld", bus.s_bresp, ok ? 2'b00 : 2'b10);
      checkOutput("awreadyBlocked", bus.s_awready, 0);
    end
    @(posedge clk); #1;
    bus.s_bready = 1'b1;
    @(posedge clk); #1;
    bus.s_bready = 1'b0;
    checkOutput("awreadyAfterB", bus.s_awready, 1);
    checkOutput("bvalidAfterB", bus.s_bvalid, 0);
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input int stall,
                        input logic [DW-1:0] expData, input logic [1:0] expResp, input logic ok);
    int lat, rdLat;
    driveAr(addr);
    lat = 0; rdLat = 0;
    do begin
      @(negedge clk); lat++;
      if (regRdEn && rdLat == 0) rdLat = lat;
    end while (!bus.s_rvalid && lat < 20);
    checkOutput("rLatency", lat, 2);
    checkOutput("rdEnLatency", rdLat, ok ? 1 : 0);
    repeat (stall) begin
      @(negedge clk);
      checkOutput("rvalidHeld", bus.s_rvalid, 1);
      checkOutput("rdataHeld", bus.s_rdata, expData);
      checkOutput("rrespHeld", bus.s_rresp, expResp);
    end
    @(posedge clk); #1;
    bus.s_rready = 1'b1;
    @(posedge clk); #1;
    bus.s_rready = 1'b0;
    checkOutput("arreadyAfterR", bus.s_arready, 1);
  endtask

  // kind 0: write, 1: read, 2: write and read presented in the same cycle
  task automatic applyStimulus(input int kind, input logic [AW-1:0] waddr, input logic [DW-1:0] data,
                               input logic [3:0] strb, input logic [AW-1:0] raddr,
                               input int awD, input int wD, input int stall);
    logic wok, rok;
    logic [DW-1:0] rd;
    logic [1:0] rr;
    case (kind)
      0: begin
        expectWrite(waddr, data, strb, wok);
        doWrite(waddr, data, strb, awD, wD, stall, wok);
      end
      1: begin
        expectRead(raddr, rd, rr, rok);
        doRead(raddr, stall, rd, rr, rok);
      end
      default: begin
        expectRead(raddr, rd, rr, rok);
        expectWrite(waddr, data, strb, wok);
        fork
          doWrite(waddr, data, strb, 0, 0, stall, wok);
          doRead(raddr, stall, rd, rr, rok);
        join
      end
    endcase
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_awready"}, bus.s_awready, 1);
    checkOutput({tag, "_wready"}, bus.s_wready, 1);
    checkOutput({tag, "_arready"}, bus.s_arready, 1);
    checkOutput({tag, "_bvalid"}, bus.s_bvalid, 0);
    checkOutput({tag, "_rvalid"}, bus.s_rvalid, 0);
    checkOutput({tag, "_bresp"}, bus.s_bresp, 0);
    checkOutput({tag, "_rresp"}, bus.s_rresp, 0);
    checkOutput({tag, "_rdata"}, bus.s_rdata, 0);
    checkOutput({tag, "_wrEn"}, regWrEn, 0);
    checkOutput({tag, "_rdEn"}, regRdEn, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ok;
    logic [AW-1:0] wa, ra;
    int kind;
    logic [3:0] strb;

    rstn = 1'b0;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata = '0;  bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    #12;
    checkResetOutputs("reset");
    checkOutput("reset_wrAddr", regWrAddr, 0);
    checkOutput("reset_rdAddr", regRdAddr, 0);
    checkOutput("reset_wrData", regWrData, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] preloading all registers");
    for (int i = 0; i < NREG; i++)
      applyStimulus(0, AW'(i * 4), $urandom, 4'hF, '0, $urandom_range(0, 2), $urandom_range(0, 2), 0);

    $display("[TB] directed cases");
    applyStimulus(0, 32'h08, 32'hDEAD_BEEF, 4'hF, '0, 0, 0, 0);
    applyStimulus(0, 32'h3C, 32'h1234_5678, 4'hF, '0, 3, 0, 0);
    applyStimulus(0, 32'h40, 32'hCAFE_F00D, 4'hF, '0, 0, 0, 1);
    applyStimulus(0, 32'h04, 32'h5555_AAAA, 4'h3, '0, 1, 0, 0);
    applyStimulus(0, 32'h34, 32'h0000_0001, 4'hF, '0, 0, 1, 0);
    applyStimulus(1, '0, '0, 4'h0, 32'h34, 0, 0, 2);
    applyStimulus(1, '0, '0, 4'h0, 32'h80, 0, 0, 0);
    applyStimulus(1, '0, '0, 4'h0, 32'h08, 0, 0, 0);
    applyStimulus(0, 32'h20, 32'hA5A5_0F0F, 4'hF, '0, 0, 0, 5);
    applyStimulus(2, 32'h24, 32'h7777_8888, 4'hF, 32'h24, 0, 0, 1);
    applyStimulus(1, '0, '0, 4'h0, 32'h24, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      wa   = AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      ra   = AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      applyStimulus(kind, wa, $urandom, strb, ra, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2));
    end

    $display("[TB] reset during WR_RESP and RD_ISSUE");
    ok = 1'b1;
    expWrQ.push_back('{idx: AW'(4), data: 32'h0BAD_CAFE});
    model[4] = 32'h0BAD_CAFE;
    bus.s_awaddr = 32'h10; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h0BAD_CAFE; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    expRdQ.push_back(AW'(5));
    bus.s_araddr = 32'h14; bus.s_arvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    @(negedge clk);
    checkOutput("preReset_bvalid", bus.s_bvalid, 1);
    checkOutput("preReset_rdEn", regRdEn, 1);
    #2 rstn = 1'b0;
    #1;
    checkResetOutputs("midReset");
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("postReset_bvalid", bus.s_bvalid, 0);
      checkOutput("postReset_rvalid", bus.s_rvalid, 0);
    end
    @(posedge clk); #1;
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    applyStimulus(1, '0, '0, 4'h0, 32'h10, 0, 0, 0);
    applyStimulus(0, 32'h18, 32'h1357_9BDF, 4'hF, '0, 0, 2, 0);
    applyStimulus(1, '0, '0, 4'h0, 32'h18, 0, 0, 0);

    repeat (3) @(posedge clk);
    checkOutput("wrQueueDrained", expWrQ.size(), 0);
    checkOutput("rdQueueDrained", expRdQ.size(), 0);
    checkOutput("bQueueDrained", expBQ.size(), 0);
    checkOutput("rQueueDrained", expRQ.size(), 0);
    checkOutput("okFlagUnused", ok, 1'b1 & rstn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/axil_reg_bridge.md
# axil_reg_bridge

AXI4-Lite slave bridging the processor's control port to the DMA controller's register port (`reg_wr_en/reg_rd_en/reg_wr_addr/reg_rd_addr/reg_wr_data/reg_rd_data`). It sits directly upstream of the DMA controller. It accepts AW, W and AR independently and converts byte addresses to word indices. It issues single-cycle register strobes and returns B/R responses with error checking for range and partial strobes.

## Interface

- `AXI_ADDR_WIDTH`, 32, AXI-Lite and register address width
- `AXI_DATA_WIDTH`, 32, data width; must be 32 or 64
- `NUM_REGS`, 16, number of implemented words; word indices ≥ NUM_REGS are errors
- `clk` in 1: single clock
- `rstn` in 1: reset; **asynchronous, active-low** (fixed)
- `s_awaddr` in AXI_ADDR_WIDTH, `s_awvalid` in 1, `s_awready` out 1
- `s_wdata` in AXI_DATA_WIDTH, `s_wstrb` in AXI_DATA_WIDTH/8, `s_wvalid` in 1, `s_wready` out 1
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1
- `s_araddr` in AXI_ADDR_WIDTH, `s_arvalid` in 1, `s_arready` out 1
- `s_rdata` out AXI_DATA_WIDTH, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1
- `reg_wr_en` out 1: one-cycle write strobe
- `reg_wr_addr` out AXI_ADDR_WIDTH: word index
- `reg_wr_data` out AXI_DATA_WIDTH: write data
- `reg_rd_en` out 1: one-cycle read strobe
- `reg_rd_addr` out AXI_ADDR_WIDTH: word index
- `reg_rd_data` in AXI_DATA_WIDTH: combinational read data, valid in the same cycle as `reg_rd_addr`

## Operation

- Word index = byte address >> log2(AXI_DATA_WIDTH/8). Low address bits are ignored.
- **Write path**
  - Holding flags `aw_held` and `w_held`. `s_awready = !aw_held`; `s_wready = !w_held`.
  - AW and W may arrive in any order or in the same cycle.
  - Write FSM states:
    - WR_IDLE: goes to WR_ISSUE when both flags are set.
    - WR_ISSUE: exactly one cycle.
    - WR_RESP: waits for `s_bready`; on the B handshake, clears both flags and returns to WR_IDLE.
  - In WR_ISSUE, `reg_wr_en = 1` only if index < NUM_REGS **and** `s_wstrb` is all ones; `bresp = OKAY (00)`.
  - If index ≥ NUM_REGS or strobe is partial: no register write, `bresp = SLVERR (10)`.
  - At most one write outstanding.
- **Read path**
  - Read FSM states:
    - RD_IDLE: `s_arready = 1`. An AR handshake latches the index and moves to RD_ISSUE.
    - RD_ISSUE: `reg_rd_en = 1` (in range only), `reg_rd_addr` = index. Captures `reg_rd_data`, or 0 with SLVERR if out of range, into `s_rdata`.
    - RD_RESP: `s_rvalid = 1` until `s_rready`, then back to RD_IDLE.
  - At most one read outstanding.
- Read and write paths are independent.
  - A read issued in the same cycle as a write to the same index returns the pre-write value.
  - The downstream block gives `reg_wr_en` priority on its own side.
- `reg_wr_addr`, `reg_wr_data` and `reg_rd_addr` hold their last values when their strobes are low.

## Timing

- Reset values (async assert on `rstn` low):
  - `s_awready`, `s_wready`, `s_arready` = 1
  - `s_bvalid`, `s_rvalid`, `reg_wr_en`, `reg_rd_en` = 0
  - `s_bresp`, `s_rresp`, `s_rdata`, `reg_*_addr`, `reg_wr_data` = 0
  - FSMs in IDLE, flags cleared
- Write latency, with the last of AW/W accepted in cycle N:
  - `reg_wr_en` high in N+1
  - `s_bvalid` high from N+2
  - Next AW/W accepted the cycle after the B handshake
- Read latency, with AR accepted in cycle N:
  - `reg_rd_en` high in N+1
  - `s_rvalid` high from N+2
  - `s_arready` high again the cycle after the R handshake
- All outputs are registered except the readies, which decode combinationally from flags and FSM state.
- `s_bvalid`/`s_rvalid` stay asserted and `bresp`/`rdata`/`rresp` stay stable until the handshake completes (AXI rule).
- Reset mid-transaction aborts it. No strobe and no response are issued after reset deasserts.

## Structure

- Shared package `sys_pkg`:
  - `axi_resp_t` enum: OKAY = 2'b00, SLVERR = 2'b10
  - `wr_state_t` and `rd_state_t` enums
  - `WORD_SHIFT = $clog2(AXI_DATA_WIDTH/8)`
- Single module, no sub-modules. The read and write FSMs are separate `always_ff` blocks.

## Test plan

- AW (0x08) and W (0xDEAD_BEEF, strb 0xF) in the same cycle → `reg_wr_en` pulse with addr 2, data 0xDEADBEEF, one cycle later; `bvalid` with OKAY a cycle after that.
- W three cycles before AW (0x3C) → no strobe until AW; `reg_wr_addr` = 15; `s_wready` low while data is held.
- AW 0x40 (index 16) → no `reg_wr_en`, `bresp` = 10. Strb 0x3 to 0x04 → no write, SLVERR.
- AR 0x34 with `reg_rd_data` = 0x1 → `reg_rd_en` pulse at addr 13; `rdata` = 0x1, OKAY. AR 0x80 → `rdata` = 0, SLVERR, no `reg_rd_en`.
- `bready` low for 5 cycles → `bvalid`/`bresp` stable, `s_awready` low; the next write is accepted only after the handshake.
- `rstn` pulled low while in WR_RESP and RD_ISSUE → all outputs at reset values immediately; no response after release.
